ccsds123_frame_ctrl: RTL and testbench
======================================

# ccsds123_frame_ctrl

Frame-level sequencer placed between the upstream sample source and the `s_axis` input of `ccsds123_top`. It admits exactly one image (NX×NY×NZ samples) at a time. It tracks the BIP coordinate of each sample and flags the last one. After the last sample it closes the input gate and waits for the compressor's `out_last` before it admits the next frame. Software or the bench controls it with a frame count and start/stop pulses.

## Interface
Parameters:
- `D`, 16: sample width.
- `NX`, 64: image columns.
- `NY`, 64: image rows.
- `NZ`, 8: bands.
- `FCNT_W`, 16: width of the frame count and of the frame counter.

Ports:
- `clk` in 1: clock.
- `areset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run; ignored while `busy`.
- `stop` in 1: pulse requesting a graceful stop after the current frame; latched; ignored in IDLE.
- `cfg_frames` in FCNT_W: frames per run, 0 = continuous; sampled on `start`.
- `up_tdata` in D, `up_tvalid` in 1, `up_tready` out 1: upstream sample stream.
- `dn_tdata` out D, `dn_tvalid` out 1, `dn_tready` in 1: to the compressor `s_axis`.
- `enc_valid` in 1, `enc_last` in 1: the compressor's `out_valid` and `out_last`.
- `sample_last` out 1: high while `dn_tdata` carries sample (NX-1, NY-1, NZ-1).
- `coord_x`, `coord_y`, `coord_z` out clog2(NX|NY|NZ): coordinate of the sample currently on `dn_tdata`.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `frame_count` out FCNT_W: frames completed in the current run.
- `err_last` out 1: sticky; cleared by `start`.

## Operation
- States: IDLE, STREAM, DRAIN.
- Gate signal `g` = (state == STREAM), decoded from registered state.
- `dn_tdata` = `up_tdata`. `dn_tvalid` = `up_tvalid & g`. `up_tready` = `dn_tready & g`. The path is purely combinational: zero latency, no buffering.
- A handshake is `dn_tvalid & dn_tready`.
- Coordinates advance in BIP order: z increments on each handshake. At NZ-1, z wraps to 0 and x increments. At NX-1, x wraps and y increments. At NY-1, all three wrap to 0.
- IDLE → STREAM on `start`. The same edge sets `frame_count`=0, latches `cfg_frames`, clears the stop latch and `err_last`, and zeroes the coordinates.
- STREAM → DRAIN on the handshake where `sample_last`=1. The coordinates wrap to 0 on that same edge.
- DRAIN → transition on `enc_valid & enc_last`. `frame_count` increments on that edge. Then:
  - if the stop latch is set, or `cfg_frames`≠0 and `frame_count`+1 == `cfg_frames`: → IDLE, with `done` pulsed the next cycle;
  - otherwise → STREAM.
- `enc_valid & enc_last` in STREAM or IDLE sets `err_last` and does not change state.
- `stop` and the frame-limit condition arriving in the same cycle give the same result: → IDLE.
- `start` and `stop` in the same IDLE cycle: `start` wins and `stop` is dropped.
- A `stop` pulse in DRAIN still lets the frame finish draining.
- `frame_count` saturates at all-ones in continuous mode.

## Timing
- Reset values: state IDLE; `up_tready`=0; `dn_tvalid`=0; `busy`=0; `done`=0; `sample_last`=0; coordinates 0; `frame_count`=0; `err_last`=0.
- `areset` asserted mid-frame returns to IDLE immediately and asynchronously. The gate closes the same instant; no handshake completes.
- `start` at edge t: `busy` and `up_tready` (given `dn_tready`) are high from cycle t+1.
- Last-sample handshake at edge t: `up_tready`=0 from t+1 onward.
- `enc_last` at edge t: STREAM is re-entered in cycle t+1 (one-cycle bubble minimum), or IDLE in t+1 with `done`=1 in t+1 only.
- `sample_last` and the coordinates are registered and change only on a handshake edge.

## Structure
- Shared include `ccsds123_ctrl_defs.vh` holds:
  - state encodings as localparams (IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2);
  - the clog2 width helper, reused by other control blocks.
- Sub-module `ccsds123_coord_counter` holds the three cascaded wrap counters and the `sample_last` decode. Its inputs are `clk`, `areset`, clear, and advance.

## Test plan
Use NX=2, NY=2, NZ=3 (12 samples/frame) and D=16.

- Reset, no `start`, `up_tvalid`=1 → `up_tready`=0 and `dn_tvalid`=0 for 50 cycles; `busy`=0.
- `cfg_frames`=1, `start`, 12 samples driven back to back, then `enc_last` 5 cycles later → 12 handshakes; coordinate sequence (z,x,y) (0,0,0),(1,0,0),(2,0,0),(0,1,0)…(2,1,1); `sample_last` on the 12th; `done` one cycle after `enc_last`; `frame_count`=1.
- `cfg_frames`=2, `up_tvalid` held high throughout → exactly 12 samples pass; `up_tready`=0 during DRAIN; the second frame starts the cycle after the first `enc_last`; `done` after the second frame.
- `cfg_frames`=0, `stop` pulsed mid-frame 3 → frame 3 completes, `frame_count`=3, `done` pulses, no sample of frame 4 is accepted.
- Random `dn_tready`/`up_tvalid` bubbles → coordinates advance only on handshakes; 12 samples/frame preserved bit-exact.
- `enc_last` during STREAM → `err_last`=1 and state unchanged. `areset` asserted at sample 7 → all outputs return to reset values; the next `start` begins at (0,0,0).

Source files
------------

// File: rtl/ccsds123_frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ccsds123_frame_ctrl_pkg
// Shared definitions for the CCSDS-123 control blocks:
//   - ctrl_state_e : frame sequencer states (IDLE=0, STREAM=1, DRAIN=2)
//   - cnt_width()  : clog2 width helper that never returns 0, so a
//                    dimension of 1 still gets a legal 1-bit counter.
// ---------------------------------------------------------------------------
package ccsds123_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } ctrl_state_e;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccsds123_coord_counter.sv
// ---------------------------------------------------------------------------
// ccsds123_coord_counter
// BIP-order coordinate tracker: z is the fastest index, then x, then y.
// Ports:
//   clk, areset  : clock, asynchronous active-high reset
//   clear        : force coordinates to (0,0,0) (start of a run)
//   advance      : one sample handshake completed this cycle
//   coord_x/y/z  : coordinate of the sample currently presented
//   sample_last  : high while the coordinate is (NX-1, NY-1, NZ-1)
// ---------------------------------------------------------------------------
module ccsds123_coord_counter
  import ccsds123_frame_ctrl_pkg::*;
#(
  parameter int NX = 64,
  parameter int NY = 64,
  parameter int NZ = 8,
  parameter int XW = cnt_width(NX),
  parameter int YW = cnt_width(NY),
  parameter int ZW = cnt_width(NZ)
) (
  input  logic          clk,
  input  logic          areset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] coord_x,
  output logic [YW-1:0] coord_y,
  output logic [ZW-1:0] coord_z,
  output logic          sample_last
);

  logic          last_x, last_y, last_z;
  logic [XW-1:0] nxt_x;
  logic [YW-1:0] nxt_y;
  logic [ZW-1:0] nxt_z;

  assign last_x = (coord_x == XW'(NX - 1));
  assign last_y = (coord_y == YW'(NY - 1));
  assign last_z = (coord_z == ZW'(NZ - 1));

  // NOTE: every output of a combinational block gets a default before any
  // branch; a path that leaves one unassigned would infer a latch.
  always_comb begin
    nxt_x = coord_x;
    nxt_y = coord_y;
    nxt_z = coord_z + ZW'(1);
    if (last_z) begin
      nxt_z = '0;
      nxt_x = coord_x + XW'(1);
      if (last_x) begin
        nxt_x = '0;
        nxt_y = last_y ? '0 : coord_y + YW'(1);
      end
    end
  end

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and is
  // tested first; the gated logic downstream depends on it acting at once.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      coord_x     <= '0;
      coord_y     <= '0;
      coord_z     <= '0;
      sample_last <= 1'b0;
    end else if (clear) begin
      coord_x     <= '0;
      coord_y     <= '0;
      coord_z     <= '0;
      sample_last <= (NX * NY * NZ == 1);
    end else if (advance) begin
      coord_x     <= nxt_x;
      coord_y     <= nxt_y;
      coord_z     <= nxt_z;
      // Registered decode of the coordinate being loaded, so sample_last is
      // aligned with the sample it describes.
      sample_last <= (nxt_x == XW'(NX - 1)) && (nxt_y == YW'(NY - 1)) &&
                     (nxt_z == ZW'(NZ - 1));
    end
  end

endmodule

// File: rtl/ccsds123_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ccsds123_frame_ctrl
// Frame sequencer in front of the CCSDS-123 compressor input. Admits one
// NX*NY*NZ image at a time, tracks the BIP coordinate of each sample, closes
// the gate after the last sample and waits for the compressor's out_last
// before opening it for the next frame.
// Ports:
//   clk, areset               : clock, asynchronous active-high reset
//   start, stop, cfg_frames   : run control (cfg_frames = 0 -> continuous)
//   up_tdata/tvalid/tready    : upstream sample stream
//   dn_tdata/tvalid/tready    : to compressor s_axis (combinational pass)
//   enc_valid, enc_last       : compressor out_valid / out_last
//   sample_last, coord_x/y/z  : position of the sample on dn_tdata
//   busy, done, frame_count   : run status
//   err_last                  : sticky, out_last seen outside DRAIN
// ---------------------------------------------------------------------------
module ccsds123_frame_ctrl
  import ccsds123_frame_ctrl_pkg::*;
#(
  parameter int D      = 16,
  parameter int NX     = 64,
  parameter int NY     = 64,
  parameter int NZ     = 8,
  parameter int FCNT_W = 16
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [FCNT_W-1:0]        cfg_frames,
  input  logic [D-1:0]             up_tdata,
  input  logic                     up_tvalid,
  output logic                     up_tready,
  output logic [D-1:0]             dn_tdata,
  output logic                     dn_tvalid,
  input  logic                     dn_tready,
  input  logic                     enc_valid,
  input  logic                     enc_last,
  output logic                     sample_last,
  output logic [cnt_width(NX)-1:0] coord_x,
  output logic [cnt_width(NY)-1:0] coord_y,
  output logic [cnt_width(NZ)-1:0] coord_z,
  output logic                     busy,
  output logic                     done,
  output logic [FCNT_W-1:0]        frame_count,
  output logic                     err_last
);

  ctrl_state_e       state;
  logic              gate;
  logic              hs;
  logic              enc_end;
  logic              limit_hit;
  logic              stop_q;
  logic [FCNT_W-1:0] frames_q;

  // Gate decoded from registered state only: reset closes it immediately.
  assign gate      = (state == ST_STREAM);
  assign dn_tdata  = up_tdata;
  assign dn_tvalid = up_tvalid & gate;
  assign up_tready = dn_tready & gate;
  assign hs        = up_tvalid & dn_tready & gate;
  assign busy      = (state != ST_IDLE);
  assign enc_end   = enc_valid & enc_last;

  // The frame finishing now is number frame_count+1 of this run.
  assign limit_hit = (frames_q != '0) &&
                     ((frame_count + FCNT_W'(1)) == frames_q);

  ccsds123_coord_counter #(
    .NX(NX),
    .NY(NY),
    .NZ(NZ)
  ) u_coord (
    .clk         (clk),
    .areset      (areset),
    .clear       ((state == ST_IDLE) && start),
    .advance     (hs),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .coord_z     (coord_z),
    .sample_last (sample_last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= ST_IDLE;
      frames_q    <= '0;
      stop_q      <= 1'b0;
      err_last    <= 1'b0;
      done        <= 1'b0;
      frame_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // start wins over a simultaneous stop or enc_last.
          if (start) begin
            state       <= ST_STREAM;
            frames_q    <= cfg_frames;
            stop_q      <= 1'b0;
            err_last    <= 1'b0;
            frame_count <= '0;
          end else if (enc_end) begin
            err_last <= 1'b1;
          end
        end

        ST_STREAM: begin
          if (stop)    stop_q   <= 1'b1;
          if (enc_end) err_last <= 1'b1;
          if (hs && sample_last) state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (enc_end) begin
            if (!(&frame_count)) frame_count <= frame_count + FCNT_W'(1);
            // A stop arriving on the closing edge counts as well.
            if (stop_q || stop || limit_hit) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end else begin
              state <= ST_STREAM;
            end
          end else if (stop) begin
            stop_q <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccsds123_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ccsds123_frame_ctrl
// Self-checking bench for ccsds123_frame_ctrl with a 2x2x3 image.
// A behavioural model tracks the run in terms of "sample index within the
// frame" and "frames finished"; a negedge process compares every output
// against it each cycle. Directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_ccsds123_frame_ctrl;

  localparam int D  = 16;
  localparam int NX = 2;
  localparam int NY = 2;
  localparam int NZ = 3;
  localparam int FW = 16;
  localparam int NS = NX * NY * NZ;

  logic          clk = 1'b0;
  logic          areset;
  logic          start, stop;
  logic [FW-1:0] cfg_frames;
  logic [D-1:0]  up_tdata, dn_tdata;
  logic          up_tvalid, up_tready, dn_tvalid, dn_tready;
  logic          enc_valid, enc_last;
  logic          sample_last;
  logic [0:0]    coord_x, coord_y;
  logic [1:0]    coord_z;
  logic          busy, done, err_last;
  logic [FW-1:0] frame_count;

  ccsds123_frame_ctrl #(
    .D(D), .NX(NX), .NY(NY), .NZ(NZ), .FCNT_W(FW)
  ) dut (
    .clk         (clk),
    .areset      (areset),
    .start       (start),
    .stop        (stop),
    .cfg_frames  (cfg_frames),
    .up_tdata    (up_tdata),
    .up_tvalid   (up_tvalid),
    .up_tready   (up_tready),
    .dn_tdata    (dn_tdata),
    .dn_tvalid   (dn_tvalid),
    .dn_tready   (dn_tready),
    .enc_valid   (enc_valid),
    .enc_last    (enc_last),
    .sample_last (sample_last),
    .coord_x     (coord_x),
    .coord_y     (coord_y),
    .coord_z     (coord_z),
    .busy        (busy),
    .done        (done),
    .frame_count (frame_count),
    .err_last    (err_last)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_run   = 0;  // a run is active
  bit          m_wait  = 0;  // frame fully sent, waiting for out_last
  bit          m_done  = 0;
  bit          m_err   = 0;
  bit          m_stop  = 0;
  int          m_idx   = 0;  // index of the next sample within the frame
  logic [FW-1:0] m_fc    = '0;
  logic [FW-1:0] m_limit = '0;

  initial begin
    forever begin
      @(posedge clk or posedge areset);
      if (areset) begin
        m_run = 0; m_wait = 0; m_done = 0; m_err = 0; m_stop = 0;
        m_idx = 0; m_fc = '0; m_limit = '0;
      end else begin
        bit accept, closing;
        accept  = up_tvalid && dn_tready && m_run && !m_wait;
        closing = enc_valid && enc_last;
        m_done  = 0;
        if (!m_run) begin
          if (start) begin
            m_run = 1; m_wait = 0; m_idx = 0; m_fc = '0;
            m_limit = cfg_frames; m_stop = 0; m_err = 0;
          end else if (closing) begin
            m_err = 1;
          end
        end else if (!m_wait) begin
          if (stop) m_stop = 1;
          if (closing) m_err = 1;
          if (accept) begin
            m_idx++;
            if (m_idx == NS) begin
              m_idx  = 0;
              m_wait = 1;
            end
          end
        end else begin
          if (stop) m_stop = 1;
          if (closing) begin
            if (m_fc != {FW{1'b1}}) m_fc++;
            if (m_stop || (m_limit != 0 && m_fc == m_limit)) begin
              m_run  = 0;
              m_wait = 0;
              m_done = 1;
            end else begin
              m_wait = 0;
            end
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int hs_cnt = 0;
  int zq[$], xq[$], yq[$];

  initial begin
    forever begin
      @(negedge clk);
      begin
        bit open;
        open = m_run && !m_wait;
        check("up_tready",   up_tready,   dn_tready && open);
        check("dn_tvalid",   dn_tvalid,   up_tvalid && open);
        check("dn_tdata",    dn_tdata,    up_tdata);
        check("busy",        busy,        m_run);
        check("done",        done,        m_done);
        check("err_last",    err_last,    m_err);
        check("frame_count", frame_count, m_fc);
        check("coord_z",     coord_z,     m_idx % NZ);
        check("coord_x",     coord_x,     (m_idx / NZ) % NX);
        check("coord_y",     coord_y,     m_idx / (NZ * NX));
        check("sample_last", sample_last, m_idx == NS - 1);
        if (!areset && dn_tvalid && dn_tready) begin
          hs_cnt++;
          zq.push_back(int'(coord_z));
          xq.push_back(int'(coord_x));
          yq.push_back(int'(coord_y));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    up_tdata = 16'($urandom);
  endtask

  task automatic pulse_start(input logic [FW-1:0] n);
    cfg_frames = n;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_frames = 16'($urandom);  // must not matter once sampled
  endtask

  task automatic pulse_enc();
    enc_valid = 1'b1;
    enc_last  = 1'b1;
    tick();
    enc_valid = 1'b0;
    enc_last  = 1'b0;
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_cnt < target && n < budget) begin
      tick();
      n++;
    end
    if (hs_cnt < target) check("wait_hs", hs_cnt, target);
  endtask

  task automatic clear_log();
    hs_cnt = 0;
    zq.delete(); xq.delete(); yq.delete();
  endtask

  int ez[NS] = '{0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
  int ex[NS] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 1};
  int ey[NS] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scenarios ----------------
  initial begin
    areset = 1'b1; start = 1'b0; stop = 1'b0; cfg_frames = '0;
    up_tdata = '0; up_tvalid = 1'b0; dn_tready = 1'b0;
    enc_valid = 1'b0; enc_last = 1'b0;
    repeat (3) tick();
    areset = 1'b0;

    // 1: no start, upstream valid -> gate stays closed
    up_tvalid = 1'b1; dn_tready = 1'b1;
    repeat (50) tick();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_up_tready", up_tready, 0);
    check("idle_hs", hs_cnt, 0);
    up_tvalid = 1'b0;
    tick();

    // 2: single frame, back-to-back samples
    clear_log();
    pulse_start(16'd1);
    @(negedge clk);
    check("start_busy", busy, 1);
    check("start_up_tready", up_tready, 1);
    tick();
    up_tvalid = 1'b1;
    wait_hs(NS, 40);
    up_tvalid = 1'b0;
    repeat (5) tick();
    pulse_enc();
    @(negedge clk);
    check("f1_done", done, 1);
    check("f1_frame_count", frame_count, 1);
    check("f1_busy", busy, 0);
    check("f1_hs", hs_cnt, NS);
    for (int i = 0; i < NS; i++) begin
      check($sformatf("seq_z%0d", i), zq[i], ez[i]);
      check($sformatf("seq_x%0d", i), xq[i], ex[i]);
      check($sformatf("seq_y%0d", i), yq[i], ey[i]);
    end
    tick();

    // 3: two frames, upstream valid held throughout
    clear_log();
    pulse_start(16'd2);
    up_tvalid = 1'b1;
    wait_hs(NS, 40);
    repeat (3) tick();
    @(negedge clk);
    check("drain_up_tready", up_tready, 0);
    check("drain_hs", hs_cnt, NS);
    pulse_enc();
    @(negedge clk);
    check("restream_up_tready", up_tready, 1);
    check("restream_done", done, 0);
    wait_hs(2 * NS, 40);
    repeat (2) tick();
    pulse_enc();
    @(negedge clk);
    check("f2_done", done, 1);
    check("f2_frame_count", frame_count, 2);
    repeat (10) tick();
    check("f2_hs", hs_cnt, 2 * NS);
    up_tvalid = 1'b0;
    tick();

    // 4: continuous mode, stop mid frame 3
    clear_log();
    pulse_start(16'd0);
    up_tvalid = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      if (f == 3) begin
        wait_hs(2 * NS + 6, 40);
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      wait_hs(f * NS, 40);
      tick();
      pulse_enc();
    end
    @(negedge clk);
    check("stop_done", done, 1);
    check("stop_frame_count", frame_count, 3);
    repeat (20) tick();
    check("stop_hs", hs_cnt, 3 * NS);
    check("stop_busy", busy, 0);
    up_tvalid = 1'b0;
    tick();

    // 5: random bubbles on both sides, out_valid noise without out_last
    clear_log();
    pulse_start(16'd3);
    for (int n = 0; n < 3000 && m_run; n++) begin
      up_tvalid = 1'($urandom);
      dn_tready = ($urandom_range(0, 3) != 0);
      enc_valid = 1'($urandom);
      enc_last  = m_wait && ($urandom_range(0, 3) == 0);
      tick();
    end
    enc_valid = 1'b0; enc_last = 1'b0; up_tvalid = 1'b0; dn_tready = 1'b1;
    @(negedge clk);
    check("rand_busy", busy, 0);
    check("rand_hs", hs_cnt, 3 * NS);
    check("rand_frame_count", frame_count, 3);
    check("rand_err", err_last, 0);
    tick();

    // 6: out_last during STREAM, then reset at sample 7
    clear_log();
    pulse_start(16'd1);
    up_tvalid = 1'b1;
    wait_hs(3, 20);
    pulse_enc();
    @(negedge clk);
    check("err_set", err_last, 1);
    check("err_busy", busy, 1);
    wait_hs(6, 20);
    #2 areset = 1'b1;
    #1;
    check("rst_up_tready", up_tready, 0);
    check("rst_dn_tvalid", dn_tvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_last, 0);
    check("rst_coord", {coord_y, coord_x, coord_z}, 0);
    check("rst_frame_count", frame_count, 0);
    tick();
    areset = 1'b0;
    tick();
    check("rst_hs", hs_cnt, 6);
    clear_log();
    pulse_start(16'd1);
    wait_hs(1, 20);
    check("restart_z", zq[0], 0);
    check("restart_x", xq[0], 0);
    check("restart_y", yq[0], 0);
    wait_hs(NS, 40);
    up_tvalid = 1'b0;
    tick();
    pulse_enc();
    @(negedge clk);
    check("restart_done", done, 1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
